// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states,
// constants and the ALU-control funct encodings that select the unit.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSVD  = 3'd6,
        OP_NOP   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // Quotient reported for any divide by zero.
    localparam logic [MDU_WIDTH-1:0] DIV0_LO = '1;

    // R-type funct codes decoded by ALU control into mdu_op.
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between ALU control, the pipeline and the multiply/divide unit.
interface mdu_if #(parameter int WIDTH = 32) ();
    logic             start;
    logic [2:0]       mdu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, mdu_op, a, b, input busy, done, hi, lo);
    modport slave  (input start, mdu_op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_sign_fix.sv
// Two-lane conditional two's-complement negation. With chain=1 the lanes form one
// 2*WIDTH value {in_hi,in_lo} and neg_hi must equal neg_lo.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_hi,
    input  logic [WIDTH-1:0] in_lo,
    input  logic             neg_hi,
    input  logic             neg_lo,
    input  logic             chain,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo
);
    localparam logic [WIDTH:0] ONE_W1 = 1;

    logic [WIDTH:0]   lo_neg;
    logic             hi_cin;
    logic [WIDTH-1:0] hi_neg;

    always_comb begin
        lo_neg = {1'b0, ~in_lo} + ONE_W1;
        // In chained mode the +1 only ripples into the upper lane when the lower lane is zero.
        hi_cin = chain ? lo_neg[WIDTH] : 1'b1;
        hi_neg = ~in_hi + {{(WIDTH-1){1'b0}}, hi_cin};
        out_lo = neg_lo ? lo_neg[WIDTH-1:0] : in_lo;
        out_hi = neg_hi ? hi_neg : in_hi;
    end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers:
// one accept cycle, WIDTH iteration cycles, one sign-fix/writeback cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    mdu_state_e         state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg, done_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH:0]     rem_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic               is_div_reg, neg_res_reg, neg_rem_reg, div0_reg;

    mdu_op_e          op;
    logic             calc_op, signed_op, div_op;
    logic             accept, mt_hi, mt_lo;
    logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] div_shift, div_diff;

    assign op = mdu_op_e'(bus.mdu_op);

    always_comb begin
        calc_op   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        div_op    = (op == OP_DIV) || (op == OP_DIVU);
    end

    mdu_sign_fix #(.WIDTH(WIDTH)) u_in_fix (
        .in_hi  (bus.a),
        .in_lo  (bus.b),
        .neg_hi (signed_op & bus.a[WIDTH-1]),
        .neg_lo (signed_op & bus.b[WIDTH-1]),
        .chain  (1'b0),
        .out_hi (mag_a),
        .out_lo (mag_b)
    );

    // Multiply negates the whole product; divide negates quotient and remainder independently.
    mdu_sign_fix #(.WIDTH(WIDTH)) u_out_fix (
        .in_hi  (is_div_reg ? rem_reg[WIDTH-1:0] : acc_reg[2*WIDTH-1:WIDTH]),
        .in_lo  (acc_reg[WIDTH-1:0]),
        .neg_hi (is_div_reg ? neg_rem_reg : neg_res_reg),
        .neg_lo (neg_res_reg),
        .chain  (~is_div_reg),
        .out_hi (fix_hi),
        .out_lo (fix_lo)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    accept = calc_op;
                    mt_hi  = (op == OP_MTHI);
                    mt_lo  = (op == OP_MTLO);
                    if (calc_op) state_next = ST_CALC;
                end
            end
            ST_CALC: if (cnt_reg == LAST_ITER) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        // The dividend shifts out of the top of the lower accumulator half into the remainder.
        div_shift = {rem_reg, acc_reg[WIDTH-1]};
        div_diff  = div_shift - {2'b00, opnd_reg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            acc_reg     <= '0;
            rem_reg     <= '0;
            opnd_reg    <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            div0_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
            done_reg  <= (state_reg == ST_FIX);
            if (accept) begin
                cnt_reg     <= '0;
                rem_reg     <= '0;
                is_div_reg  <= div_op;
                acc_reg     <= {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
                opnd_reg    <= div_op ? mag_b : mag_a;
                neg_res_reg <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_rem_reg <= signed_op & bus.a[WIDTH-1];
                div0_reg    <= (bus.b == '0);
            end
            if (mt_hi) hi_reg <= bus.a;
            if (mt_lo) lo_reg <= bus.a;
            if (state_reg == ST_CALC) begin
                cnt_reg <= cnt_reg + 1'b1;
                if (!is_div_reg) begin
                    acc_reg <= {mul_sum, acc_reg[WIDTH-1:1]};
                end else if (div_diff[WIDTH+1]) begin
                    rem_reg             <= div_shift[WIDTH:0];
                    acc_reg[WIDTH-1:0]  <= {acc_reg[WIDTH-2:0], 1'b0};
                end else begin
                    rem_reg             <= div_diff[WIDTH:0];
                    acc_reg[WIDTH-1:0]  <= {acc_reg[WIDTH-2:0], 1'b1};
                end
            end
            if (state_reg == ST_FIX) begin
                hi_reg <= fix_hi;
                lo_reg <= (is_div_reg && div0_reg) ? DIV0_LO[WIDTH-1:0] : fix_lo;
            end
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: arithmetic results, latency, MT ops, ignored
// requests while busy, back-to-back issue and reset abort.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single edge; returns at the negedge after the accept edge.
    task automatic start_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.a      = a;
        bus.b      = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mdu_op = OP_NOP;
        bus.a      = 32'hA5A5_A5A5;
        bus.b      = 32'h0;
    endtask

    // Waits for done; 'already' is the number of busy cycles seen by the caller.
    task automatic wait_result(input string tag, input int already,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        bit seen;
        cnt  = already;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) cnt++;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, 32'(cnt), 32'd33);
        check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
        $display("%s: hi=%h lo=%h busy_cycles=%0d", tag, bus.hi, bus.lo, cnt);
    endtask

    task automatic done_clears(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.mdu_op = OP_NOP;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        rst = 1'b0;
        $display("reset: busy=%0b done=%0b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);

        start_op(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        check("mthi_done", 32'(bus.done), 32'd0);
        $display("mthi: hi=%h busy=%0b", bus.hi, bus.busy);

        start_op(OP_MTLO, 32'h1234_5678, 32'h0);
        check("mtlo_lo", bus.lo, 32'h1234_5678);
        check("mtlo_hi", bus.hi, 32'hDEAD_BEEF);
        $display("mtlo: lo=%h", bus.lo);

        start_op(OP_NOP, 32'h0, 32'h0);
        start_op(OP_RSVD, 32'h0, 32'h0);
        check("nop_busy", 32'(bus.busy), 32'd0);
        check("nop_hi", bus.hi, 32'hDEAD_BEEF);
        check("nop_lo", bus.lo, 32'h1234_5678);
        $display("nop/reserved: hi=%h lo=%h", bus.hi, bus.lo);

        // DIVU with a MULT presented mid-CALC; HI must hold its old value meanwhile.
        start_op(OP_DIVU, 32'd100, 32'd7);
        check("divu_hold_hi", bus.hi, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mdu_op = OP_MULT;
        bus.a      = 32'd2;
        bus.b      = 32'd3;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mdu_op = OP_NOP;
        wait_result("divu_mid_mult", 3, 32'h0000_0002, 32'h0000_000E);
        done_clears("divu_mid_mult");

        // Back-to-back: second request issued in the done cycle.
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 1, 32'hFFFF_FFFE, 32'h0000_0001);
        bus.start  = 1'b1;
        bus.mdu_op = OP_MULT;
        bus.a      = 32'hFFFF_FFFD;
        bus.b      = 32'd5;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mdu_op = OP_NOP;
        bus.a      = 32'h5A5A_5A5A;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done_clear", 32'(bus.done), 32'd0);
        wait_result("mult_neg3x5", 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        done_clears("mult_neg3x5");

        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_neg7by2", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        start_op(OP_DIV, 32'h1234_5678, 32'h0);
        wait_result("div_by0", 1, 32'h1234_5678, 32'hFFFF_FFFF);

        start_op(OP_DIV, 32'hFFFF_FFFB, 32'h0);
        wait_result("div_neg_by0", 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        start_op(OP_DIVU, 32'hF000_0000, 32'h0);
        wait_result("divu_by0", 1, 32'hF000_0000, 32'hFFFF_FFFF);

        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_ovf", 1, 32'h0000_0000, 32'h8000_0000);

        start_op(OP_MULT, 32'h0001_0000, 32'hFFFF_0000);
        wait_result("mult_wide", 1, 32'hFFFF_FFFF, 32'h0000_0000);

        // Reset during CALC aborts the operation without a done pulse.
        start_op(OP_MULT, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.hi, 32'h0);
        check("abort_lo", bus.lo, 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        $display("abort: busy=%0b hi=%h lo=%h done_pulses=%0d", bus.busy, bus.hi, bus.lo, done_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. It sits beside the ALU, downstream of ALU control, which decodes mult/multu/div/divu/mthi/mtlo funct codes into an `mdu_op` plus a one-cycle `start`. The unit runs 32 radix-2 iterations while holding `busy`. The pipeline stall logic uses `busy`, and mfhi/mflo read `hi`/`lo` directly.

## Interface
- `WIDTH`, 32: operand width. Iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request strobe, sampled each rising edge
- `mdu_op`  in  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, NOP=7; 6 is reserved and treated as NOP
- `a`  in  WIDTH  rs operand (dividend / multiplicand / mt source)
- `b`  in  WIDTH  rt operand (divisor / multiplier)
- `busy`  out  1  high while a computation is in flight
- `done`  out  1  one-cycle pulse when `hi`/`lo` take a computed result
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, FSM=IDLE, internal datapath registers cleared.
- FSM states: IDLE, CALC, FIX.
  - IDLE → CALC when `start`=1 and `mdu_op`∈{0..3}.
  - CALC → FIX after `WIDTH` iterations, counted by a log2(WIDTH)+1-bit counter.
  - FIX → IDLE unconditionally.
- On accept:
  - For signed ops, latch magnitudes of `a` and `b` plus the sign flags.
  - For unsigned ops, latch `a` and `b` raw.
  - Later changes on `a`/`b` do not affect the operation.
- Multiply: shift-add over a 2×WIDTH accumulator, one multiplier bit per CALC cycle.
- Divide: restoring divide, one quotient bit per CALC cycle; the remainder register is WIDTH+1 bits.
- FIX stage:
  - Multiply: negate the 2×WIDTH product if the operand signs differ.
  - Divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Write `hi`=product[2W-1:W] or remainder, and `lo`=product[W-1:0] or quotient.
- Divide by zero (b=0, signed or unsigned): `lo`=all ones, `hi`=`a`. Latency is unchanged.
- Signed 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. This wraps naturally and needs no special case.
- MTHI/MTLO with `start`=1 in IDLE: `hi` (resp. `lo`) ← `a` at that edge. `busy` and `done` are not asserted.
- `start` while `busy`=1 is ignored entirely, including MT ops. Holding issue is the upstream stall's responsibility.
- `start` with NOP or reserved op: no effect.
- During CALC/FIX, `hi`/`lo` keep their prior values.
- `rst` mid-operation aborts the computation: IDLE, `hi`=`lo`=0, no `done` pulse.

## Timing
- Accept edge E0: `busy`=1 from E0.
- CALC spans edges E1..E32 (for `WIDTH`=32).
- FIX at edge E33: `hi`/`lo` updated, `done`=1 for the cycle after E33, `busy`=0 after E33.
- `busy` is high for exactly WIDTH+1 cycles. A new `start` is accepted at E34 or later.
- Back-to-back: a `start` in the cycle where `done`=1 is accepted (FSM already IDLE).
- MT latency: one edge. `done` stays 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `mdu_pkg`: `mdu_op` encodings, FSM state enum, the DIV0_LO constant (all ones).
- The ALU-control funct encodings for mult/multu/div/divu/mthi/mtlo (0x18/0x19/0x1A/0x1B/0x11/0x13) are added to the shared control encode definitions.
- Natural sub-module: `mdu_sign_fix`, combinational. It does operand magnitude and result negation, and is instantiated once for the input side and once for FIX.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 busy cycles: `hi`=0xFFFFFFFE, `lo`=0x00000001, single `done` pulse.
- MULT a=-3, b=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIV a=-7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=100, b=7 → `lo`=0x0000000E, `hi`=0x00000002.
- Edge cases:
  - DIV a=0x12345678, b=0 → `hi`=0x12345678, `lo`=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Control sequencing:
  - MTHI 0xDEADBEEF in IDLE → `hi`=0xDEADBEEF next cycle, `busy`=0.
  - MULT issued mid-CALC → ignored, first result unchanged.
  - `rst` on cycle 10 of CALC → `busy`=0, `hi`=`lo`=0, no `done`.
